// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding,
// main-decoder opcode values and the default exception vector.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the instruction held by the fetch unit.
// All additions wrap modulo 2^32.
module pc_next_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  input  logic        branch_taken_i,
  input  logic        exception_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_bits;

  assign pc_plus4      = pc_i + 32'd4;
  assign branch_off    = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:28], instr_i[25:0], 2'b00};
  assign unused_bits   = ^{instr_i[31:26], jr_addr_i[1:0]};

  always_comb begin
    next_pc_o = pc_plus4;
    if (exception_i) begin
      next_pc_o = EXC_VECTOR;
    end else if (jump_i && jr_i) begin
      next_pc_o = {jr_addr_i[31:2], 2'b00};
    end else if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, holds the
// fetched word for the decoder and redirects on the accept handshake.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  input  logic        exception
);

  fetch_state_e state_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  next_pc_d;

  pc_next_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_calc (
    .pc_i           (pc_q),
    .instr_i        (instr_q),
    .jump_i         (jump),
    .jr_i           (jr),
    .jr_addr_i      (jr_addr),
    .branch_taken_i (branch_taken),
    .exception_i    (exception),
    .next_pc_o      (next_pc_d)
  );

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      pc_q          <= 32'd0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        ST_FETCH: begin
          state_q    <= ST_WAIT;
          imem_req_q <= 1'b0;
        end
        ST_WAIT: begin
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            pc_q          <= fetch_pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            fetch_pc_q    <= next_pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= ST_FETCH;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = opcode_of(instr_q);
  assign pc          = pc_q;

endmodule
